// File: rtl/oci_mem_arbiter.sv
// oci_mem_arbiter: shares single-port OCI debug RAM between JTAG and CPU; `OCIMEM_ARB_AUTOINC_EN selects the JTAG auto-increment pointer
module oci_mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              debugack,
  input  logic              jt_req,
  input  logic              jt_write,
  input  logic              jt_load_addr,
  input  logic [ADDR_W-1:0] jt_addr,
  input  logic [DATA_W-1:0] jt_wdata,
  output logic              jt_ack,
  output logic [DATA_W-1:0] jt_rdata,
  input  logic              cpu_req,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d, jt_txn_addr;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] jt_rdata_q, jt_rdata_d, cpu_rdata_q, cpu_rdata_d;
  logic              grant_cpu, rd_done;
  // owner/last_grant: 1 means CPU; JTAG wins under debugack or when CPU was granted last
  assign grant_cpu = cpu_req & ~(jt_req & (debugack | last_grant_q));
  assign rd_done   = (state_q == RESP) & ~write_q;
  assign ram_en    = state_q == ACCESS;
  assign ram_we    = ram_en & write_q;
  assign jt_ack    = (state_q == RESP) & ~owner_q;
  assign cpu_ack   = (state_q == RESP) & owner_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign jt_rdata  = jt_rdata_q;
  assign cpu_rdata = cpu_rdata_q;
`ifdef OCIMEM_ARB_AUTOINC_EN
  logic [ADDR_W-1:0] jt_ptr_q, jt_ptr_d;
  assign jt_txn_addr = jt_ptr_q;
  // pointer load takes precedence over the post-ack increment; increment wraps
  always_comb jt_ptr_d = jt_load_addr ? jt_addr : jt_ack ? jt_ptr_q + ADDR_W'(1) : jt_ptr_q;
  // pointer register
  always_ff @(posedge clk or posedge reset)
    if (reset) jt_ptr_q <= '0;
    else jt_ptr_q <= jt_ptr_d;
`else
  logic unused_load;
  assign unused_load = jt_load_addr;
  assign jt_txn_addr = jt_addr;
`endif
  // sequencer: IDLE latches the winner's transaction, ACCESS strobes the RAM, RESP acks
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    write_d      = write_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    if (state_q == IDLE && (jt_req || cpu_req)) begin
      state_d      = ACCESS;
      owner_d      = grant_cpu;
      last_grant_d = grant_cpu;
      write_d      = grant_cpu ? cpu_write : jt_write;
      ram_addr_d   = grant_cpu ? cpu_addr : jt_txn_addr;
      ram_wdata_d  = grant_cpu ? cpu_wdata : jt_wdata;
    end else if (state_q == ACCESS) state_d = RESP;
    else if (state_q != IDLE) state_d = IDLE;
  end
  // read data lands in the owner's register during RESP
  always_comb begin
    jt_rdata_d  = (rd_done && !owner_q) ? ram_rdata : jt_rdata_q;
    cpu_rdata_d = (rd_done && owner_q) ? ram_rdata : cpu_rdata_q;
  end
  // state and datapath registers; reset leaves CPU as last grant so JTAG wins the first tie
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      write_q      <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      jt_rdata_q   <= '0;
      cpu_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      write_q      <= write_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      jt_rdata_q   <= jt_rdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
    end
endmodule
